// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA timing generator with pixel-rate divider
module vga_sync_gen #(
  parameter int TICK_DIV = 4,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISP);
  localparam logic [9:0] V_VIS    = 10'(V_DISP);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;
  logic [9:0]    x_next;
  logic [9:0]    y_next;
  logic          frame_wrap;
  logic          hsync_next;
  logic          vsync_next;
  logic          video_next;

  // Next divider/counter values; syncs are decoded from these so they line up with the position
  always_comb begin
    div_next   = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    x_next     = pixel_x;
    y_next     = pixel_y;
    frame_wrap = 1'b0;
    if (p_tick) begin
      if (pixel_x == X_LAST) begin
        x_next = '0;
        if (pixel_y == Y_LAST) begin
          y_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          y_next = pixel_y + 10'd1;
        end
      end else begin
        x_next = pixel_x + 10'd1;
      end
    end
    hsync_next = !((x_next >= HS_START) && (x_next <= HS_END));
    vsync_next = !((y_next >= VS_START) && (y_next <= VS_END));
    video_next = (x_next < H_VIS) && (y_next < V_VIS);
  end

  // Register every output; reset forces the idle, non-syncing state
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      p_tick      <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_next;
      p_tick      <= (div_next == DIV_LAST);
      pixel_x     <= x_next;
      pixel_y     <= y_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      video_on    <= video_next;
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen against a position-arithmetic model
module tb_vga_sync_gen;

  localparam int RUN = 30000;

  localparam int PD  [3] = '{4, 3, 1};
  localparam int PHD [3] = '{640, 8, 5};
  localparam int PHF [3] = '{16, 2, 1};
  localparam int PHS [3] = '{96, 3, 2};
  localparam int PHB [3] = '{48, 2, 1};
  localparam int PVD [3] = '{480, 6, 4};
  localparam int PVF [3] = '{10, 2, 1};
  localparam int PVS [3] = '{2, 2, 1};
  localparam int PVB [3] = '{33, 1, 2};

  typedef struct packed {
    logic       rst_edge;
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       fs;
  } exp_t;

  logic       clk;
  logic       rst [3];
  logic       p_tick_o [3];
  logic [9:0] px [3];
  logic [9:0] py [3];
  logic       hs_o [3];
  logic       vs_o [3];
  logic       von_o [3];
  logic       fs_o [3];

  exp_t sb [3][$];
  int   checks;
  int   failures;

  vga_sync_gen #(.TICK_DIV(4), .H_DISP(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
                 .V_DISP(480), .V_FP(10), .V_SYNC(2), .V_BP(33)) u_dut0 (
    .clk(clk), .rst(rst[0]), .p_tick(p_tick_o[0]), .pixel_x(px[0]), .pixel_y(py[0]),
    .hsync(hs_o[0]), .vsync(vs_o[0]), .video_on(von_o[0]), .frame_start(fs_o[0]));

  vga_sync_gen #(.TICK_DIV(3), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                 .V_DISP(6), .V_FP(2), .V_SYNC(2), .V_BP(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .p_tick(p_tick_o[1]), .pixel_x(px[1]), .pixel_y(py[1]),
    .hsync(hs_o[1]), .vsync(vs_o[1]), .video_on(von_o[1]), .frame_start(fs_o[1]));

  vga_sync_gen #(.TICK_DIV(1), .H_DISP(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
                 .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(2)) u_dut2 (
    .clk(clk), .rst(rst[2]), .p_tick(p_tick_o[2]), .pixel_x(px[2]), .pixel_y(py[2]),
    .hsync(hs_o[2]), .vsync(vs_o[2]), .video_on(von_o[2]), .frame_start(fs_o[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs after the k-th edge since the last reset edge
  function automatic exp_t model(input int i, input int k, input logic r);
    exp_t e;
    int d, ht, vt, a, ap, pos, x, y;
    e = '0;
    if (r) begin
      e.rst_edge = 1'b1;
      e.hs = 1'b1;
      e.vs = 1'b1;
      return e;
    end
    d  = PD[i];
    ht = PHD[i] + PHF[i] + PHS[i] + PHB[i];
    vt = PVD[i] + PVF[i] + PVS[i] + PVB[i];
    // pixel advances happen at edges j where edge j-1 (j-1 >= 1) left p_tick high
    a  = (k / d) - ((d == 1) ? 1 : 0);
    ap = (k <= 1) ? 0 : (((k - 1) / d) - ((d == 1) ? 1 : 0));
    pos = a % (ht * vt);
    x = pos % ht;
    y = pos / ht;
    e.p_tick = ((k % d) == d - 1);
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.hs  = !((x >= PHD[i] + PHF[i]) && (x < PHD[i] + PHF[i] + PHS[i]));
    e.vs  = !((y >= PVD[i] + PVF[i]) && (y < PVD[i] + PVF[i] + PVS[i]));
    e.von = (x < PHD[i]) && (y < PVD[i]);
    e.fs  = (a != ap) && (pos == 0);
    return e;
  endfunction

  // Stimulus: drives resets and pushes the expected response for every edge
  initial begin
    int   k [3];
    int   hold [3];
    exp_t last [3];
    int   trig0;
    bit   b_done;
    bit   fire;
    checks = 0;
    failures = 0;
    b_done = 1'b0;
    trig0 = $urandom_range(8000, 12000);
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      k[i] = 0;
      hold[i] = 0;
    end
    repeat (3) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) sb[i].push_back(model(i, 0, 1'b1));
    end
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    for (int cyc = 0; cyc < RUN; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (rst[i]) k[i] = 0;
        else k[i] = k[i] + 1;
        last[i] = model(i, k[i], rst[i]);
        sb[i].push_back(last[i]);
      end
      for (int i = 0; i < 3; i++) begin
        if (rst[i]) begin
          if (hold[i] > 0) hold[i] = hold[i] - 1;
          else rst[i] = 1'b0;
        end else begin
          case (i)
            0: fire = (cyc == trig0);
            1: fire = !b_done && (cyc > 1100) && (last[1].x == 10'd11) && (last[1].y == 10'd9);
            default: fire = ($urandom_range(0, 399) == 0);
          endcase
          if (fire) begin
            rst[i] = 1'b1;
            hold[i] = $urandom_range(0, 2);
            if (i == 1) b_done = 1'b1;
          end
        end
      end
    end
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sb[i].size() != 0) begin
        failures++;
        $display("FAIL drain dut%0d: %0d entries left, required 0", i, sb[i].size());
      end
    end
    checks++;
    if (!b_done) begin
      failures++;
      $display("FAIL midframe_reset_issued: got 0 required 1");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: compares every cycle's outputs and measures sync/frame spacing
  initial begin
    exp_t e;
    exp_t a;
    int   hrun;
    bit   hvalid;
    int   fcnt [3];
    bit   fvalid [3];
    hrun = 0;
    hvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fcnt[i] = 0;
      fvalid[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (sb[i].size() > 0) begin
          e = sb[i].pop_front();
          a.rst_edge = e.rst_edge;
          a.p_tick = p_tick_o[i];
          a.x = px[i];
          a.y = py[i];
          a.hs = hs_o[i];
          a.vs = vs_o[i];
          a.von = von_o[i];
          a.fs = fs_o[i];
          checks++;
          if (a !== e) begin
            failures++;
            $display("FAIL outputs dut%0d t=%0t: got tick=%b x=%0d y=%0d hs=%b vs=%b von=%b fs=%b required tick=%b x=%0d y=%0d hs=%b vs=%b von=%b fs=%b",
                     i, $time, a.p_tick, a.x, a.y, a.hs, a.vs, a.von, a.fs,
                     e.p_tick, e.x, e.y, e.hs, e.vs, e.von, e.fs);
          end
          if (i == 0) begin
            if (e.rst_edge) begin
              hrun = 0;
              hvalid = 1'b0;
            end else if (!hs_o[0]) begin
              if (hrun == 0) hvalid = 1'b1;
              hrun++;
            end else if (hrun > 0) begin
              if (hvalid) begin
                checks++;
                if (hrun != PHS[0] * PD[0]) begin
                  failures++;
                  $display("FAIL hsync_width: got %0d clks required %0d", hrun, PHS[0] * PD[0]);
                end
              end
              hrun = 0;
            end
          end else begin
            fcnt[i]++;
            if (e.rst_edge) fvalid[i] = 1'b0;
            if (fs_o[i]) begin
              if (fvalid[i]) begin
                checks++;
                if (fcnt[i] != (PHD[i] + PHF[i] + PHS[i] + PHB[i]) * (PVD[i] + PVF[i] + PVS[i] + PVB[i]) * PD[i]) begin
                  failures++;
                  $display("FAIL frame_period dut%0d: got %0d clks required %0d", i, fcnt[i],
                           (PHD[i] + PHF[i] + PHS[i] + PHB[i]) * (PVD[i] + PVF[i] + PVS[i] + PVB[i]) * PD[i]);
                end
              end
              fcnt[i] = 0;
              fvalid[i] = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
